// File: rtl/tap_ctrl_if.sv
// TAP controller signal bundle: JTAG pins, BSR serial return, FSM strobes and decode.
// master drives TMS/TDI/bsr_tdo and observes the rest; slave is the controller.
interface tap_ctrl_if #(
    parameter int IR_WIDTH = 4
);
    logic                TMS;
    logic                TDI;
    logic                bsr_tdo;
    logic                TDO;
    logic                tdo_en;
    logic [3:0]          tap_state;
    logic                tlr_reset;
    logic                ir_capture;
    logic                ir_shift;
    logic                ir_update;
    logic                dr_capture;
    logic                dr_shift;
    logic                dr_update;
    logic                bsr_select;
    logic                mode;
    logic [IR_WIDTH-1:0] instr;

    modport master (
        output TMS, TDI, bsr_tdo,
        input  TDO, tdo_en, tap_state, tlr_reset,
        input  ir_capture, ir_shift, ir_update,
        input  dr_capture, dr_shift, dr_update,
        input  bsr_select, mode, instr
    );

    modport slave (
        input  TMS, TDI, bsr_tdo,
        output TDO, tdo_en, tap_state, tlr_reset,
        output ir_capture, ir_shift, ir_update,
        output dr_capture, dr_shift, dr_update,
        output bsr_select, mode, instr
    );
endinterface

// File: rtl/tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register, BYPASS/IDCODE DRs, TDO mux.
// Ports: TCK clock, TRST sync active-high reset, bus (slave) carrying TMS/TDI/bsr_tdo in and TDO/strobes/decode out.
module tap_ctrl #(
    parameter int                  IR_WIDTH   = 4,
    parameter logic [31:0]         IDCODE_VAL = 32'h1234_5001,
    parameter logic [IR_WIDTH-1:0] OP_EXTEST  = 'h0,
    parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = 'h1,
    parameter logic [IR_WIDTH-1:0] OP_IDCODE  = 'h2,
    parameter logic [IR_WIDTH-1:0] OP_BYPASS  = 'hF
) (
    input logic         TCK,
    input logic         TRST,
    tap_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PA_DR  = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PA_IR  = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } state_t;

    state_t              state;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] instr;
    logic                bypass;
    logic [31:0]         idcode;

    logic is_extest;
    logic is_sample;
    logic id_sel;
    logic byp_sel;
    logic tdo;

    function automatic state_t next_state(input state_t s, input logic tms);
        state_t n;
        n = s;
        case (s)
            TLR:    n = tms ? TLR    : RTI;
            RTI:    n = tms ? SEL_DR : RTI;
            SEL_DR: n = tms ? SEL_IR : CAP_DR;
            CAP_DR: n = tms ? EX1_DR : SH_DR;
            SH_DR:  n = tms ? EX1_DR : SH_DR;
            EX1_DR: n = tms ? UPD_DR : PA_DR;
            PA_DR:  n = tms ? EX2_DR : PA_DR;
            EX2_DR: n = tms ? UPD_DR : SH_DR;
            UPD_DR: n = tms ? SEL_DR : RTI;
            SEL_IR: n = tms ? TLR    : CAP_IR;
            CAP_IR: n = tms ? EX1_IR : SH_IR;
            SH_IR:  n = tms ? EX1_IR : SH_IR;
            EX1_IR: n = tms ? UPD_IR : PA_IR;
            PA_IR:  n = tms ? EX2_IR : PA_IR;
            EX2_IR: n = tms ? UPD_IR : SH_IR;
            UPD_IR: n = tms ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    // Unknown opcodes fall through to BYPASS so exactly one DR is always selected.
    assign is_extest = (instr == OP_EXTEST);
    assign is_sample = (instr == OP_SAMPLE);
    assign id_sel    = (instr == OP_IDCODE);
    assign byp_sel   = (instr == OP_BYPASS) || !(is_extest || is_sample || id_sel);

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state  <= TLR;
            instr  <= OP_IDCODE;
            ir_sr  <= '0;
            bypass <= 1'b0;
            idcode <= IDCODE_VAL;
        end else begin
            state <= next_state(state, bus.TMS);

            if (state == CAP_IR)
                ir_sr <= IR_WIDTH'(1);
            else if (state == SH_IR)
                ir_sr <= {bus.TDI, ir_sr[IR_WIDTH-1:1]};

            if (state == TLR)
                instr <= OP_IDCODE;
            else if (state == UPD_IR)
                instr <= ir_sr;

            if (state == CAP_DR) begin
                if (byp_sel) bypass <= 1'b0;
                if (id_sel)  idcode <= IDCODE_VAL;
            end else if (state == SH_DR) begin
                if (byp_sel) bypass <= bus.TDI;
                if (id_sel)  idcode <= {bus.TDI, idcode[31:1]};
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state == SH_IR)
            tdo = ir_sr[0];
        else if (state == SH_DR) begin
            if (is_extest || is_sample)
                tdo = bus.bsr_tdo;
            else if (id_sel)
                tdo = idcode[0];
            else
                tdo = bypass;
        end
    end

    assign bus.TDO        = tdo;
    assign bus.tdo_en     = (state == SH_IR) || (state == SH_DR);
    assign bus.tap_state  = state;
    assign bus.tlr_reset  = (state == TLR);
    assign bus.ir_capture = (state == CAP_IR);
    assign bus.ir_shift   = (state == SH_IR);
    assign bus.ir_update  = (state == UPD_IR);
    assign bus.dr_capture = (state == CAP_DR);
    assign bus.dr_shift   = (state == SH_DR);
    assign bus.dr_update  = (state == UPD_DR);
    assign bus.bsr_select = is_extest || is_sample;
    assign bus.mode       = is_extest;
    assign bus.instr      = instr;

endmodule

// File: tb/tb_tap_ctrl.sv
// Bench for tap_ctrl: directed scan sequences plus random TMS/TDI traffic against a table-driven model.
// Every tick compares all outputs with the model; directed steps add fixed expectations.
module tb_tap_ctrl;

    localparam logic [31:0] IDV = 32'h1234_5001;

    logic TCK;
    logic TRST;

    tap_ctrl_if #(.IR_WIDTH(4)) bus ();

    tap_ctrl #(
        .IR_WIDTH  (4),
        .IDCODE_VAL(IDV),
        .OP_EXTEST (4'h0),
        .OP_SAMPLE (4'h1),
        .OP_IDCODE (4'h2),
        .OP_BYPASS (4'hF)
    ) dut (
        .TCK (TCK),
        .TRST(TRST),
        .bus (bus)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    int vectors     = 0;
    int miscompares = 0;
    bit chk         = 0;
    logic trst_v    = 1'b1;

    // Next-state tables indexed by state number, one per TMS value.
    int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          m_st   = 0;
    int          m_ir   = 0;
    int          m_ins  = 2;
    int          m_byp  = 0;
    logic [31:0] m_id   = IDV;
    logic [31:0] idv    = IDV;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_bsel();
        return (m_ins == 0) || (m_ins == 1);
    endfunction

    task automatic compare_model();
        logic [31:0] e_tdo;
        logic [31:0] e_str;
        e_tdo = 0;
        if (m_st == 11)
            e_tdo = 32'(m_ir & 1);
        else if (m_st == 4)
            e_tdo = m_bsel() ? 32'(bus.bsr_tdo)
                  : (m_ins == 2) ? 32'(m_id[0]) : 32'(m_byp);
        e_str = {25'd0, m_st == 0, m_st == 10, m_st == 11, m_st == 15,
                 m_st == 3, m_st == 4, m_st == 8};
        check("state", 32'(bus.tap_state), 32'(m_st));
        check("instr", 32'(bus.instr), 32'(m_ins));
        check("tdo", 32'(bus.TDO), e_tdo);
        check("tdo_en", 32'(bus.tdo_en), 32'(m_st == 4 || m_st == 11));
        check("strobes", {25'd0, bus.tlr_reset, bus.ir_capture, bus.ir_shift,
              bus.ir_update, bus.dr_capture, bus.dr_shift, bus.dr_update}, e_str);
        check("decode", {30'd0, bus.bsr_select, bus.mode},
              {30'd0, m_bsel(), m_ins == 0});
    endtask

    task automatic model_step(input logic tms, input logic tdi, input logic rst);
        bit byp_sel;
        if (rst) begin
            m_st = 0; m_ins = 2; m_ir = 0; m_byp = 0; m_id = IDV;
            return;
        end
        byp_sel = !m_bsel() && (m_ins != 2);
        if (m_st == 10) m_ir = 1;
        if (m_st == 11) m_ir = (m_ir >> 1) + (int'(tdi) * 8);
        if (m_st == 0)  m_ins = 2;
        if (m_st == 15) m_ins = m_ir;
        if (m_st == 3) begin
            if (byp_sel)   m_byp = 0;
            if (m_ins == 2) m_id = IDV;
        end
        if (m_st == 4) begin
            if (byp_sel)   m_byp = int'(tdi);
            if (m_ins == 2) m_id = {tdi, m_id[31:1]};
        end
        m_st = tms ? nx1[m_st] : nx0[m_st];
    endtask

    task automatic tick(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        TRST    = trst_v;
        #1;
        if (chk) compare_model();
        @(posedge TCK);
        model_step(tms, tdi, trst_v);
        #1;
    endtask

    task automatic shift_chk(input logic tms, input logic tdi, input logic e, input string tag);
        bus.TMS = tms;
        bus.TDI = tdi;
        #1;
        check(tag, 32'(bus.TDO), 32'(e));
        tick(tms, tdi);
    endtask

    task automatic load_ir(input logic [3:0] op);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
        tick(1, 0);
        tick(0, 0);
    endtask

    initial begin
        int seq [5] = '{5, 8, 2, 9, 0};
        logic prev;
        logic t;
        bus.TMS     = 1'b0;
        bus.TDI     = 1'b0;
        bus.bsr_tdo = 1'b0;
        TRST        = 1'b1;

        // Reset
        trst_v = 1'b1;
        tick(0, 0);
        chk = 1;
        check("rst_state", 32'(bus.tap_state), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'h2);
        check("rst_tlr", 32'(bus.tlr_reset), 32'd1);
        check("rst_strobes", {26'd0, bus.ir_capture, bus.ir_shift, bus.ir_update,
              bus.dr_capture, bus.dr_shift, bus.dr_update}, 32'd0);
        check("rst_tdo", {30'd0, bus.TDO, bus.tdo_en}, 32'd0);
        trst_v = 1'b0;
        tick(0, 0);
        check("rti", 32'(bus.tap_state), 32'd1);

        // Five TMS=1 from SH_DR
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1, 0);
            check("tms_reset", 32'(bus.tap_state), 32'(seq[i]));
        end
        check("tms_reset_instr", 32'(bus.instr), 32'h2);

        // Load EXTEST
        tick(0, 0);
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        shift_chk(0, 0, 1, "ir_tdo0");
        shift_chk(0, 0, 0, "ir_tdo1");
        shift_chk(0, 0, 0, "ir_tdo2");
        shift_chk(1, 0, 0, "ir_tdo3");
        tick(1, 0);
        tick(0, 0);
        check("extest_instr", 32'(bus.instr), 32'h0);
        check("extest_dec", {30'd0, bus.bsr_select, bus.mode}, 32'd3);

        // IDCODE after reset
        trst_v = 1'b1;
        tick(0, 0);
        trst_v = 1'b0;
        tick(0, 0);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 32; i++) shift_chk(0, 0, idv[i], "idcode_bit");
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);

        // BYPASS
        load_ir(4'hF);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        check("byp_bsel", 32'(bus.bsr_select), 32'd0);
        shift_chk(0, 1, 0, "byp0");
        shift_chk(0, 0, 1, "byp1");
        shift_chk(0, 1, 0, "byp2");
        shift_chk(0, 1, 1, "byp3");
        shift_chk(1, 1, 1, "byp4");
        tick(0, 0);
        tick(0, 0);
        tick(1, 0);
        tick(0, 0);
        shift_chk(1, 0, 1, "byp_pause_hold");
        tick(1, 0);
        tick(0, 0);

        // Unknown opcode behaves as bypass
        load_ir(4'h5);
        check("unk_instr", 32'(bus.instr), 32'h5);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t = 1'($urandom_range(0, 1));
            shift_chk(0, t, prev, "unk_delay");
            prev = t;
        end
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);

        // SAMPLE: TDO follows bsr_tdo
        load_ir(4'h1);
        check("sample_dec", {30'd0, bus.bsr_select, bus.mode}, 32'd2);
        tick(1, 0);
        tick(0, 0);
        tick(0, 0);
        for (int i = 0; i < 6; i++) begin
            bus.bsr_tdo = 1'(i & 1);
            shift_chk(0, 1'($urandom_range(0, 1)), 1'(i & 1), "sample_tdo");
        end
        tick(1, 0);
        tick(1, 0);
        tick(0, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            trst_v      = ($urandom_range(0, 149) == 0);
            bus.bsr_tdo = 1'($urandom_range(0, 1));
            tick(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)));
        end
        trst_v = 1'b0;
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("final_tlr", 32'(bus.tap_state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
